// File: rtl/fft_twiddle_gen.sv
// Twiddle-factor and butterfly-mode generator for one radix-2 SDF stage.
// Tracks the sample index within a frame, including stall, flush and clear.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous return to idle, highest priority
//   in_valid     sample present (ignored while ready=0)
//   in_last      with in_valid: final sample, starts a DELAY-cycle flush
//   ready        low only while flushing
//   state        0 fill, 1 bypass, 2 butterfly
//   w_r, w_i     twiddle cos(pi k/DELAY) - j sin(pi k/DELAY), 1.0 = 2^FRAC
module fft_twiddle_gen #(
    parameter int DELAY = 4,
    parameter int W     = 24,
    parameter int FRAC  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         ready,
    output logic [1:0]   state,
    output logic [W-1:0] w_r,
    output logic [W-1:0] w_i
);

    localparam int LB = $clog2(DELAY);
    localparam int CW = LB + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t           DMSK = cnt_t'(DELAY - 1);
    localparam cnt_t           DVAL = cnt_t'(DELAY);
    localparam logic [W-1:0]   ONE  = W'(1) << FRAC;

    // Quarter-wave cosine entry, already scaled to FRAC bits with
    // round-half-up. Evaluated at elaboration only (Taylor series in
    // 2^-30 fixed point), so each entry folds to a constant.
    function automatic logic [16:0] c_entry(input int j);
        longint x, x2, term, acc, r;
        x    = (longint'(j) * 64'sd863554413089) >>> 16;
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        acc  = term;
        for (int i = 1; i < 12; i++) begin
            term = -(((term * x2) >>> 30) / longint'((2*i-1) * (2*i)));
            acc  = acc + term;
        end
        r = (acc + 64'sd8192) >>> 14;
        if (FRAC < 16)
            r = (r + (64'sd1 <<< (15 - FRAC))) >>> (16 - FRAC);
        return 17'(r);
    endfunction

    logic [16:0] ctab [0:128];

    for (genvar j = 0; j <= 128; j++) begin : g_tab
        localparam logic [16:0] CV = c_entry(j);
        assign ctab[j] = CV;
    end

    // ph holds n mod 2*DELAY; fill marks n < DELAY.
    cnt_t ph, ph_n, fcnt, fcnt_n, nxt;
    logic fill, fill_n, flush, flush_n;

    always_comb begin
        ph_n    = ph;
        fill_n  = fill;
        flush_n = flush;
        fcnt_n  = fcnt;
        nxt     = ph + cnt_t'(1);
        if (clear) begin
            ph_n    = '0;
            fill_n  = 1'b1;
            flush_n = 1'b0;
            fcnt_n  = '0;
        end else if (flush) begin
            if (fcnt == DMSK) begin
                ph_n    = '0;
                fill_n  = 1'b1;
                flush_n = 1'b0;
                fcnt_n  = '0;
            end else begin
                ph_n   = nxt;
                fill_n = fill && (nxt != DVAL);
                fcnt_n = fcnt + cnt_t'(1);
            end
        end else if (in_valid) begin
            ph_n   = nxt;
            fill_n = fill && (nxt != DVAL);
            if (in_last) begin
                flush_n = 1'b1;
                fcnt_n  = '0;
            end
        end
    end

    // Decode the next index so registered outputs describe the
    // current sample. Past fill, m = ph xor DELAY, so ph[LB]=1 is
    // the bypass half and ph[LB]=0 is the butterfly half with k in
    // the low bits.
    cnt_t          k;
    logic [8:0]    e;
    logic [7:0]    cidx, sidx;
    logic [W-1:0]  cv, sv;
    logic          is_b;
    logic [1:0]    state_d;
    logic [W-1:0]  wr_d, wi_d;

    always_comb begin
        k    = ph_n & DMSK;
        e    = 9'(k) << (8 - LB);
        is_b = !fill_n && !ph_n[LB];
        cidx = (e <= 9'd128) ? 8'(e) : 8'(9'd256 - e);
        sidx = (e <= 9'd128) ? 8'(9'd128 - e) : 8'(e - 9'd128);
        cv   = W'(ctab[cidx]);
        sv   = W'(ctab[sidx]);
        state_d = 2'd2;
        unique case (1'b1)
            fill_n:   state_d = 2'd0;
            ph_n[LB]: state_d = 2'd1;
            default:  state_d = 2'd2;
        endcase
        wr_d = ONE;
        wi_d = '0;
        if (is_b) begin
            wr_d = (e > 9'd128) ? -cv : cv;
            wi_d = -sv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph    <= '0;
            fill  <= 1'b1;
            flush <= 1'b0;
            fcnt  <= '0;
            ready <= 1'b1;
            state <= 2'd0;
            w_r   <= ONE;
            w_i   <= '0;
        end else begin
            ph    <= ph_n;
            fill  <= fill_n;
            flush <= flush_n;
            fcnt  <= fcnt_n;
            ready <= !flush_n;
            state <= state_d;
            w_r   <= wr_d;
            w_i   <= wi_d;
        end
    end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen at DELAY=4 and DELAY=256 (FRAC=8).
// Hand-computed vector table plus sequences for stall, flush, clear, reset.
module tb_fft_twiddle_gen;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        clear_a = 0, valid_a = 0, last_a = 0, ready_a;
    logic [1:0]  state_a;
    logic [23:0] wr_a, wi_a;

    logic        clear_b = 0, valid_b = 0, last_b = 0, ready_b;
    logic [1:0]  state_b;
    logic [23:0] wr_b, wi_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_twiddle_gen #(.DELAY(4), .W(24), .FRAC(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a),
        .in_valid(valid_a), .in_last(last_a), .ready(ready_a),
        .state(state_a), .w_r(wr_a), .w_i(wi_a)
    );

    fft_twiddle_gen #(.DELAY(256), .W(24), .FRAC(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b),
        .in_valid(valid_b), .in_last(last_b), .ready(ready_b),
        .state(state_b), .w_r(wr_b), .w_i(wi_b)
    );

    typedef struct {
        logic v;
        logic l;
        int   st;
        int   wr;
        int   wi;
        logic rdy;
    } vec_t;

    vec_t tbl [18];

    function automatic int cq(input int j);
        return int'($floor(65536.0 * $cos(PI * j / 256.0) + 0.5));
    endfunction

    function automatic int sc(input int c);
        return (c + 128) >>> 8;
    endfunction

    task automatic ref_out(input int d, input int n,
                           output int st, output int wr, output int wi);
        int m, kk, e, c, s;
        st = 0; wr = 256; wi = 0;
        if (n >= d) begin
            m = (n - d) % (2 * d);
            if (m < d) begin
                st = 1;
            end else begin
                kk = m - d;
                e = kk * (256 / d);
                if (e <= 128) begin
                    c = sc(cq(e));
                    s = sc(cq(128 - e));
                end else begin
                    c = -sc(cq(256 - e));
                    s = sc(cq(e - 128));
                end
                st = 2; wr = c; wi = -s;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [1:0] s,
                       input logic [23:0] a, input logic [23:0] b,
                       input logic r, input int es, input int ea,
                       input int eb, input logic er);
        logic [1:0] es2;
        es2 = es[1:0];
        checks++;
        if (s !== es2 || $signed(a) !== ea || $signed(b) !== eb
            || r !== er) begin
            failures++;
            $display("FAIL %s: got st=%0d wr=%0d wi=%0d rdy=%0d want st=%0d wr=%0d wi=%0d rdy=%0d",
                     nm, s, $signed(a), $signed(b), r, es, ea, eb, er);
        end
    endtask

    task automatic chk_a(input string nm, input int n, input logic er);
        int st, wr, wi;
        ref_out(4, n, st, wr, wi);
        chk(nm, state_a, wr_a, wi_a, ready_a, st, wr, wi, er);
    endtask

    initial begin
        int n;
        int st, wr, wi;

        tbl[0]  = '{1, 0, 0, 256, 0, 1};
        tbl[1]  = '{1, 0, 0, 256, 0, 1};
        tbl[2]  = '{1, 0, 0, 256, 0, 1};
        tbl[3]  = '{1, 0, 0, 256, 0, 1};
        tbl[4]  = '{1, 0, 1, 256, 0, 1};
        tbl[5]  = '{1, 0, 1, 256, 0, 1};
        tbl[6]  = '{1, 0, 1, 256, 0, 1};
        tbl[7]  = '{1, 0, 1, 256, 0, 1};
        tbl[8]  = '{1, 0, 2, 256, 0, 1};
        tbl[9]  = '{1, 0, 2, 181, -181, 1};
        tbl[10] = '{1, 0, 2, 0, -256, 1};
        tbl[11] = '{1, 1, 2, -181, -181, 1};
        tbl[12] = '{1, 0, 1, 256, 0, 0};
        tbl[13] = '{0, 0, 1, 256, 0, 0};
        tbl[14] = '{1, 1, 1, 256, 0, 0};
        tbl[15] = '{1, 0, 1, 256, 0, 0};
        tbl[16] = '{0, 0, 0, 256, 0, 1};
        tbl[17] = '{0, 0, 0, 256, 0, 1};

        #12;
        chk("reset_a", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        chk("reset_b", state_b, wr_b, wi_b, ready_b, 0, 256, 0, 1);
        @(negedge clk);
        rst_n = 1;

        // Continuous frame with in_last on sample 11, then flush.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("tbl_%0d", i), state_a, wr_a, wi_a, ready_a,
                tbl[i].st, tbl[i].wr, tbl[i].wi, tbl[i].rdy);
            valid_a = tbl[i].v;
            last_a  = tbl[i].l;
        end

        // Stall pattern: valid toggles, n only moves on valid cycles.
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk_a($sformatf("stall_%0d", i), n, 1'b1);
            valid_a = (i % 2 == 0);
            last_a  = 0;
            if (valid_a) n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_a($sformatf("run_%0d", n), n, 1'b1);
            valid_a = 1;
            n++;
        end

        // Clear mid-butterfly (n=17 -> k=1), valid in same cycle ignored.
        @(negedge clk);
        chk("pre_clear", state_a, wr_a, wi_a, ready_a, 2, 181, -181, 1);
        clear_a = 1;
        valid_a = 1;
        @(negedge clk);
        chk("clear_bfly", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        clear_a = 0;
        valid_a = 1;

        // Short frame of two samples: still a full 4-cycle flush.
        @(negedge clk);
        chk_a("short_n1", 1, 1'b1);
        valid_a = 1;
        last_a  = 1;
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            chk_a($sformatf("short_flush_%0d", i), i, 1'b0);
            valid_a = 1;
            last_a  = 0;
        end
        @(negedge clk);
        chk("short_idle", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        valid_a = 1;
        last_a  = 1;

        // One-sample frame, clear on its second flush cycle.
        @(negedge clk);
        chk_a("one_flush1", 1, 1'b0);
        valid_a = 0;
        last_a  = 0;
        @(negedge clk);
        chk_a("one_flush2", 2, 1'b0);
        clear_a = 1;
        @(negedge clk);
        chk("clear_flush", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        clear_a = 0;
        valid_a = 1;
        @(negedge clk);
        chk_a("after_clear_n1", 1, 1'b1);
        valid_a = 0;

        // Asynchronous reset mid-frame, off the clock edge.
        @(negedge clk);
        chk("pre_frame", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        clear_a = 1;
        @(negedge clk);
        clear_a = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            valid_a = 1;
        end
        @(negedge clk);
        valid_a = 0;
        chk("pre_rst", state_a, wr_a, wi_a, ready_a, 2, 181, -181, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst", state_a, wr_a, wi_a, ready_a, 0, 256, 0, 1);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_a($sformatf("post_rst_%0d", i), i, 1'b1);
            valid_a = 1;
        end
        @(negedge clk);
        valid_a = 0;

        // DELAY=256: full fill, bypass and butterfly halves.
        for (int i = 0; i < 768; i++) begin
            @(negedge clk);
            ref_out(256, i, st, wr, wi);
            chk($sformatf("d256_%0d", i), state_b, wr_b, wi_b, ready_b,
                st, wr, wi, 1'b1);
            if (i == 576)
                chk("d256_k64", state_b, wr_b, wi_b, ready_b,
                    2, 181, -181, 1);
            if (i == 640)
                chk("d256_k128", state_b, wr_b, wi_b, ready_b,
                    2, 0, -256, 1);
            if (i == 704)
                chk("d256_k192", state_b, wr_b, wi_b, ready_b,
                    2, -181, -181, 1);
            valid_b = 1;
        end
        @(negedge clk);
        chk("d256_bypass2", state_b, wr_b, wi_b, ready_b, 1, 256, 0, 1);
        valid_b = 0;
        clear_b = 1;
        @(negedge clk);
        chk("d256_clear", state_b, wr_b, wi_b, ready_b, 0, 256, 0, 1);
        clear_b = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
